// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel counters, syncs, blanking, line/frame
// markers and a linear framebuffer address, stepped by a pixel-rate enable.
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned SYNC_POL  = 0,
    parameter int unsigned HW        = 10,
    parameter int unsigned VW        = 10,
    parameter int unsigned AW        = 19
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          line_start,
    output logic          frame_start,
    output logic [AW-1:0] pix_addr
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_VISIBLE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_VISIBLE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;
    localparam logic        SYNC_ON  = 1'(SYNC_POL);

    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;
    logic [AW-1:0] addr_nxt;
    logic          h_wrap;
    logic          v_wrap;
    logic          origin_nxt;
    logic          vis_nxt;
    logic          hs_nxt;
    logic          vs_nxt;

    // Next raster position; all registered outputs are derived from it so
    // they line up with the counters without skew.
    always_comb begin
        h_wrap     = (hcount == HW'(H_TOTAL - 1));
        v_wrap     = (vcount == VW'(V_TOTAL - 1));
        h_nxt      = h_wrap ? '0 : hcount + HW'(1);
        v_nxt      = vcount;
        if (h_wrap) begin
            v_nxt = v_wrap ? '0 : vcount + VW'(1);
        end
        origin_nxt = h_wrap && v_wrap;
        vis_nxt    = (h_nxt < HW'(H_VISIBLE)) && (v_nxt < VW'(V_VISIBLE));
        hs_nxt     = (h_nxt >= HW'(HS_START)) && (h_nxt <= HW'(HS_END));
        vs_nxt     = (v_nxt >= VW'(VS_START)) && (v_nxt <= VW'(VS_END));
        // Address advances only when landing on a visible pixel; blanking holds it.
        addr_nxt   = pix_addr;
        if (origin_nxt) begin
            addr_nxt = '0;
        end else if (vis_nxt) begin
            addr_nxt = pix_addr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            video_on    <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            pix_addr    <= '0;
        end else if (pix_en) begin
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            hsync       <= hs_nxt ? SYNC_ON : ~SYNC_ON;
            vsync       <= vs_nxt ? SYNC_ON : ~SYNC_ON;
            video_on    <= vis_nxt;
            line_start  <= h_wrap;
            frame_start <= origin_nxt;
            pix_addr    <= addr_nxt;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a default-timing instance for line-level
// behaviour and a shrunken active-high instance for frame-level behaviour.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Default 640x480 instance
    logic        reset_d = 1'b1;
    logic        pe_d    = 1'b1;
    logic [9:0]  hc_d, vc_d;
    logic        hs_d, vs_d, von_d, ls_d, fs_d;
    logic [18:0] addr_d;

    vga_sync_gen dut (
        .clk(clk), .reset(reset_d), .pix_en(pe_d),
        .hcount(hc_d), .vcount(vc_d), .hsync(hs_d), .vsync(vs_d),
        .video_on(von_d), .line_start(ls_d), .frame_start(fs_d),
        .pix_addr(addr_d)
    );

    // Small 16x12 instance: H total 24 (sync 18..21), V total 19 (sync 14..15)
    logic        reset_s = 1'b1;
    logic        pe_s    = 1'b0;
    logic [4:0]  hc_s, vc_s;
    logic        hs_s, vs_s, von_s, ls_s, fs_s;
    logic [7:0]  addr_s;

    vga_sync_gen #(
        .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1), .HW(5), .VW(5), .AW(8)
    ) dut_s (
        .clk(clk), .reset(reset_s), .pix_en(pe_s),
        .hcount(hc_s), .vcount(vc_s), .hsync(hs_s), .vsync(vs_s),
        .video_on(von_s), .line_start(ls_s), .frame_start(fs_s),
        .pix_addr(addr_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Framebuffer address at (h,v): visible pixels index directly, horizontal
    // blanking keeps the line's last pixel, vertical blanking keeps the max.
    function automatic int addr_of(input int h, input int v, input int hv, input int vv);
        if (v >= vv) return hv * vv - 1;
        if (h >= hv) return v * hv + hv - 1;
        return v * hv + h;
    endfunction

    task automatic expect_d(input int h, input int v, input bit ls, input bit fs);
        chk("d_hcount", 32'(hc_d), 32'(h));
        chk("d_vcount", 32'(vc_d), 32'(v));
        chk("d_hsync", 32'(hs_d), (h >= 656 && h <= 751) ? 0 : 1);
        chk("d_vsync", 32'(vs_d), (v >= 490 && v <= 491) ? 0 : 1);
        chk("d_video_on", 32'(von_d), (h < 640 && v < 480) ? 1 : 0);
        chk("d_line_start", 32'(ls_d), 32'(ls));
        chk("d_frame_start", 32'(fs_d), 32'(fs));
        chk("d_pix_addr", 32'(addr_d), 32'(addr_of(h, v, 640, 480)));
    endtask

    task automatic expect_s(input int h, input int v, input bit ls, input bit fs);
        chk("s_hcount", 32'(hc_s), 32'(h));
        chk("s_vcount", 32'(vc_s), 32'(v));
        chk("s_hsync", 32'(hs_s), (h >= 18 && h <= 21) ? 1 : 0);
        chk("s_vsync", 32'(vs_s), (v >= 14 && v <= 15) ? 1 : 0);
        chk("s_video_on", 32'(von_s), (h < 16 && v < 12) ? 1 : 0);
        chk("s_line_start", 32'(ls_s), 32'(ls));
        chk("s_frame_start", 32'(fs_s), 32'(fs));
        chk("s_pix_addr", 32'(addr_s), 32'(addr_of(h, v, 16, 12)));
    endtask

    initial begin
        int h, v, pos, vs_lines_steps, max_addr;

        // Reset held 3 clocks with pix_en high dominates the enable
        repeat (3) tick();
        expect_d(0, 0, 0, 0);
        chk("d_rst_hsync_inactive", 32'(hs_d), 1);
        reset_d = 1'b0;
        pe_d    = 1'b0;
        tick();
        expect_d(0, 0, 0, 0);

        // One line at 1-in-4 enable: counts, syncs, blanking, address hold, wrap
        for (int i = 1; i <= 800; i++) begin
            h = i % 800;
            v = i / 800;
            pe_d = 1'b1;
            tick();
            expect_d(h, v, (i == 800), 0);
            pe_d = 1'b0;
            for (int k = 0; k < 3; k++) begin
                tick();
                expect_d(h, v, 0, 0);
            end
        end
        chk("d_addr_next_line", 32'(addr_d), 640);

        // Small instance: release from reset, no marker
        reset_s = 1'b0;
        tick();
        expect_s(0, 0, 0, 0);

        // Full small frame at continuous enable
        vs_lines_steps = 0;
        max_addr = 0;
        pe_s = 1'b1;
        for (int i = 1; i <= 24 * 19; i++) begin
            h = i % 24;
            v = (i / 24) % 19;
            tick();
            expect_s(h, v, (h == 0), (h == 0 && v == 0));
            if (vs_s === 1'b1) vs_lines_steps++;
            if (int'(addr_s) > max_addr) max_addr = int'(addr_s);
        end
        chk("s_vsync_active_steps", 32'(vs_lines_steps), 48);
        chk("s_max_addr", 32'(max_addr), 191);

        // Advance to (10,7) then freeze 100 clocks
        pos = 0;
        for (int i = 0; i < 7 * 24 + 10; i++) begin
            pos++;
            tick();
            expect_s(pos % 24, pos / 24, (pos % 24 == 0), 0);
        end
        pe_s = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            expect_s(10, 7, 0, 0);
        end
        chk("s_freeze_addr", 32'(addr_s), 122);

        // Advance into both sync pulses at (20,14), then reset mid-frame
        pe_s = 1'b1;
        for (int i = 0; i < 7 * 24 + 10; i++) begin
            pos++;
            tick();
            expect_s(pos % 24, pos / 24, (pos % 24 == 0), 0);
        end
        chk("s_pre_reset_hsync", 32'(hs_s), 1);
        chk("s_pre_reset_vsync", 32'(vs_s), 1);
        reset_s = 1'b1;
        tick();
        expect_s(0, 0, 0, 0);
        reset_s = 1'b0;
        tick();
        expect_s(1, 0, 0, 0);
        chk("s_first_step_addr", 32'(addr_s), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- VGA raster timing generator; sits directly downstream of the pixel-rate divider.
- Consumes the divider's one-cycle pulse as a pixel-clock enable.
- Produces horizontal/vertical counters, sync pulses, a blanking indicator, frame/line markers and a linear framebuffer pixel address for the VGA display path of the pipelined CPU.
- Fully synchronous to the system clock; no derived clocks.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
- HW, 10, hcount width; must hold H_TOTAL-1
- VW, 10, vcount width; must hold V_TOTAL-1
- AW, 19, pix_addr width; must hold H_VISIBLE*V_VISIBLE-1

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- pix_en  input  1  pixel-step enable (divider output); one pixel advance per clk with pix_en=1
- hcount  output  HW  current column, 0..H_TOTAL-1
- vcount  output  VW  current line, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, level per SYNC_POL
- vsync  output  1  vertical sync, level per SYNC_POL
- video_on  output  1  1 when hcount<H_VISIBLE and vcount<V_VISIBLE
- line_start  output  1  one-clk pulse when hcount becomes 0
- frame_start  output  1  one-clk pulse when (hcount,vcount) becomes (0,0)
- pix_addr  output  AW  linear index of the current visible pixel

Behaviour:
- Derived constants: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
- One clock; reset is synchronous and active-high. The clock port is clk and the reset port is reset.
- All outputs are registered. hsync, vsync, video_on and pix_addr always correspond to the hcount/vcount values presented in the same cycle; there is no skew between them.
- Reset (dominates pix_en):
  - hcount=0, vcount=0, video_on=1.
  - hsync=vsync=~SYNC_POL (inactive).
  - line_start=0, frame_start=0, pix_addr=0.
- Clock edge with pix_en=0: all counters, syncs, video_on and pix_addr hold; line_start and frame_start are 0.
- Clock edge with pix_en=1:
  - hcount increments.
  - If hcount==H_TOTAL-1: hcount goes to 0 and vcount increments.
  - If additionally vcount==V_TOTAL-1: vcount goes to 0.
- hsync is active iff H_VISIBLE+H_FP <= hcount <= H_VISIBLE+H_FP+H_SYNC-1 (656..751 at defaults).
- vsync is active iff V_VISIBLE+V_FP <= vcount <= V_VISIBLE+V_FP+V_SYNC-1 (490..491 at defaults).
- line_start=1 for exactly the clk cycle in which hcount first shows 0 after a wrap.
- frame_start=1 for exactly the clk cycle in which (0,0) first appears after a wrap.
- Neither marker pulses on release from reset.
- pix_addr is counter-based; no multiplier.
  - Increments by 1 on each pix_en step that moves between two visible pixels, including the step from the last visible pixel of a line to the first visible pixel of the next visible line.
  - Holds its value through blanking.
  - Returns to 0 on the step into (0,0).
  - Invariant: when video_on=1, pix_addr == vcount*H_VISIBLE + hcount.
  - Maximum value: H_VISIBLE*V_VISIBLE-1 (307199).
- pix_en asserted on consecutive clocks is legal; every asserted cycle is one pixel step.
- Reset mid-frame returns to the reset state on the next edge. The first pix_en after reset moves to (1,0) with pix_addr=1.

Test Plan:
- Reset asserted for 3 clk with pix_en=1, then released → hcount=0, vcount=0, hsync=1, vsync=1, video_on=1, pix_addr=0, frame_start=0.
- pix_en pulsing every 4th clk (divider n=2), 800 pulses → hcount counts 0..799 then 0; vcount=1; line_start high exactly 1 clk at the wrap; values hold on non-enable clocks.
- Sweep one line → hsync=0 exactly for hcount 656..751; video_on=0 for hcount 640..799; pix_addr=639 at (639,0), holds 639 through blanking, =640 at (0,1).
- Full frame at pix_en=1 continuous (420000 steps) → vsync=0 exactly for vcount 490..491; pix_addr reaches 307199 at (639,479); frame_start pulses once on return to (0,0) with pix_addr=0.
- pix_en held low 100 clk at (300,200) → all outputs frozen, pix_addr=128300, no marker pulses.
- Reset asserted at (700,495) with pix_en=1 → next cycle all outputs at reset values (hsync/vsync inactive); next pix_en gives hcount=1, pix_addr=1.
